// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 codes for the data-memory arbiter.
package dmem_arb_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dmem_align_check.sv
// Flags a request whose byte address is not naturally aligned for its access size.
module dmem_align_check
   import dmem_arb_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lo,
   output logic       misaligned
);

   // Unrecognised size codes go to memory untouched, so they are never flagged.
   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         F3_B, F3_BU: misaligned = 1'b0;
         F3_H, F3_HU: misaligned = addr_lo[0];
         F3_W:        misaligned = |addr_lo;
         default:     misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (port 0 = MEM stage, port 1 = debug/loader).
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to port 0.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   input  logic [2:0]            p0_req_funct3,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
   output logic                  p0_rsp_err,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   input  logic [2:0]            p1_req_funct3,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
   output logic                  p1_rsp_err,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       owner_q, owner_d;
   logic       err_pend_q, err_pend_d;

   logic                  grant;
   logic                  accept;
   logic                  issue;
   logic                  misaligned;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [2:0]            sel_funct3;
   logic                  rd_rsp;

   // With no valid request the grant parks on the last winner; it is ignored then anyway.
   always_comb begin
      grant = last_grant_q;
`ifdef DMEM_ARB_RR_EN
      if (p0_req_valid && p1_req_valid) grant = ~last_grant_q;
      else if (p0_req_valid)            grant = 1'b0;
      else if (p1_req_valid)            grant = 1'b1;
`else
      if (p0_req_valid)      grant = 1'b0;
      else if (p1_req_valid) grant = 1'b1;
`endif
   end

   assign sel_we     = grant ? p1_req_we     : p0_req_we;
   assign sel_addr   = grant ? p1_req_addr   : p0_req_addr;
   assign sel_wdata  = grant ? p1_req_wdata  : p0_req_wdata;
   assign sel_funct3 = grant ? p1_req_funct3 : p0_req_funct3;

   dmem_align_check u_align (
      .funct3     (sel_funct3),
      .addr_lo    (sel_addr[1:0]),
      .misaligned (misaligned)
   );

   assign accept = (state_q == IDLE) && (p0_req_valid || p1_req_valid);
   assign issue  = accept && !misaligned;

   assign p0_req_ready = accept && !grant;
   assign p1_req_ready = accept &&  grant;

   assign mem_read_en  = issue && !sel_we;
   assign mem_write_en = issue &&  sel_we;
   assign mem_address  = issue ? sel_addr   : '0;
   assign mem_data_in  = issue ? sel_wdata  : '0;
   assign mem_funct3   = issue ? sel_funct3 : 3'b000;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      err_pend_d   = accept && misaligned;
      if (accept) begin
         last_grant_d = grant;
         owner_d      = grant;
      end
      case (state_q)
         IDLE:    if (mem_read_en) state_d = RD_WAIT;
         RD_WAIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         err_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         err_pend_q   <= err_pend_d;
      end
   end

   // Load data is passed straight through from memory during the wait cycle.
   assign rd_rsp       = (state_q == RD_WAIT);
   assign p0_rsp_valid = (rd_rsp || err_pend_q) && !owner_q;
   assign p1_rsp_valid = (rd_rsp || err_pend_q) &&  owner_q;
   assign p0_rsp_err   = err_pend_q && !owner_q;
   assign p1_rsp_err   = err_pend_q &&  owner_q;
   assign p0_rsp_rdata = (rd_rsp && !owner_q) ? mem_data_out : '0;
   assign p1_rsp_rdata = (rd_rsp &&  owner_q) ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

   typedef struct {
      bit          port;
      bit          err;
      logic [31:0] data;
      int          due;
   } rsp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        p0_req_valid = 1'b0, p0_req_ready, p0_req_we = 1'b0;
   logic [11:0] p0_req_addr = '0;
   logic [31:0] p0_req_wdata = '0;
   logic [2:0]  p0_req_funct3 = '0;
   logic        p0_rsp_valid, p0_rsp_err;
   logic [31:0] p0_rsp_rdata;
   logic        p1_req_valid = 1'b0, p1_req_ready, p1_req_we = 1'b0;
   logic [11:0] p1_req_addr = '0;
   logic [31:0] p1_req_wdata = '0;
   logic [2:0]  p1_req_funct3 = '0;
   logic        p1_rsp_valid, p1_rsp_err;
   logic [31:0] p1_rsp_rdata;
   logic        mem_read_en, mem_write_en;
   logic [11:0] mem_address;
   logic [31:0] mem_data_in;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_data_out;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   logic        rqV [2];
   logic        rqWe [2];
   logic [11:0] rqA [2];
   logic [31:0] rqD [2];
   logic [2:0]  rqF [2];
   bit          acc [2];

   rsp_t        expQ [$];
   logic [31:0] shadow [int];
   bit          modelBusy = 1'b0;
   bit          modelLast = 1'b1;

   logic [2:0]  f3Tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_funct3(p0_req_funct3),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_funct3(p1_req_funct3),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
   );

   function automatic logic [31:0] initWord(input logic [11:0] a);
      return {8'hC3, 4'h0, a, ~a[7:0]};
   endfunction

   function automatic logic [31:0] expectedWord(input logic [11:0] a);
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return initWord(a);
   endfunction

   // Access size in bytes; an access is misaligned when the address is not a multiple of it.
   function automatic bit isMisaligned(input logic [2:0] f3, input logic [11:0] a);
      int size;
      case (f3)
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 1;
      endcase
      return (int'(a) % size) != 0;
   endfunction

   // Word-per-address data memory: read data appears the cycle after mem_read_en.
   logic [31:0] memEnv [0:4095];
   logic [31:0] memOut = '0;
   bit          envReady = 1'b0;
   assign mem_data_out = memOut;

   always @(posedge clock) begin
      if (!envReady) begin
         for (int i = 0; i < 4096; i++) memEnv[i] <= initWord(12'(i));
         envReady <= 1'b1;
      end else begin
         if (mem_write_en) memEnv[mem_address] <= mem_data_in;
         if (mem_read_en)  memOut <= memEnv[mem_address];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, cycle, actual, expected);
      end
   endtask

   // One clock of traffic: drive the requests, advance the model, compare request-side outputs.
   task automatic applyStimulus();
      bit          g;
      bit          expRdy0, expRdy1, expRe, expWe;
      logic [11:0] ea;
      logic [31:0] ed;
      logic [2:0]  ef;
      rsp_t        e;
      @(posedge clock);
      #1;
      cycle++;
      p0_req_valid = rqV[0]; p0_req_we = rqWe[0]; p0_req_addr = rqA[0];
      p0_req_wdata = rqD[0]; p0_req_funct3 = rqF[0];
      p1_req_valid = rqV[1]; p1_req_we = rqWe[1]; p1_req_addr = rqA[1];
      p1_req_wdata = rqD[1]; p1_req_funct3 = rqF[1];
      acc[0] = 1'b0; acc[1] = 1'b0;
      expRdy0 = 1'b0; expRdy1 = 1'b0; expRe = 1'b0; expWe = 1'b0;
      ea = '0; ed = '0; ef = '0;
      if (modelBusy) begin
         modelBusy = 1'b0;
      end else if (rqV[0] || rqV[1]) begin
`ifdef DMEM_ARB_RR_EN
         g = (rqV[0] && rqV[1]) ? !modelLast : rqV[1];
`else
         g = !rqV[0];
`endif
         modelLast = g;
         acc[g] = 1'b1;
         if (g) expRdy1 = 1'b1; else expRdy0 = 1'b1;
         ea = rqA[g]; ed = rqD[g]; ef = rqF[g];
         if (isMisaligned(ef, ea)) begin
            e.port = g; e.err = 1'b1; e.data = '0; e.due = cycle + 1;
            expQ.push_back(e);
         end else if (rqWe[g]) begin
            expWe = 1'b1;
            shadow[int'(ea)] = ed;
         end else begin
            expRe = 1'b1;
            e.port = g; e.err = 1'b0; e.data = expectedWord(ea); e.due = cycle + 1;
            expQ.push_back(e);
            modelBusy = 1'b1;
         end
      end
      #1;
      checkOutput("p0_ready", 32'(p0_req_ready), 32'(expRdy0));
      checkOutput("p1_ready", 32'(p1_req_ready), 32'(expRdy1));
      checkOutput("mem_read_en", 32'(mem_read_en), 32'(expRe));
      checkOutput("mem_write_en", 32'(mem_write_en), 32'(expWe));
      if (expRe || expWe) begin
         checkOutput("mem_address", 32'(mem_address), 32'(ea));
         checkOutput("mem_funct3", 32'(mem_funct3), 32'(ef));
      end
      if (expWe) checkOutput("mem_data_in", mem_data_in, ed);
      for (int p = 0; p < 2; p++) if (acc[p]) rqV[p] = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clock);
      #1;
      cycle++;
      rqV[0] = 1'b0; rqV[1] = 1'b0;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      reset_n = 1'b0;
      expQ.delete();
      modelBusy = 1'b0;
      modelLast = 1'b1;
      #1;
      checkOutput("rst_p0_ready", 32'(p0_req_ready), 0);
      checkOutput("rst_p1_ready", 32'(p1_req_ready), 0);
      checkOutput("rst_rsp_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
      checkOutput("rst_rsp_err", {30'd0, p1_rsp_err, p0_rsp_err}, 0);
      checkOutput("rst_p0_rdata", p0_rsp_rdata, 0);
      checkOutput("rst_p1_rdata", p1_rsp_rdata, 0);
      checkOutput("rst_mem_strobes", {30'd0, mem_read_en, mem_write_en}, 0);
      checkOutput("rst_mem_address", 32'(mem_address), 0);
      @(posedge clock);
      #1;
      cycle++;
      reset_n = 1'b1;
   endtask

   task automatic setReq(input int p, input bit we, input logic [11:0] a,
                         input logic [31:0] d, input logic [2:0] f);
      rqV[p] = 1'b1; rqWe[p] = we; rqA[p] = a; rqD[p] = d; rqF[p] = f;
   endtask

   task automatic newRandomReq(input int p);
      logic [11:0] a;
      a = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & 12'hFFC;
      setReq(p, 1'($urandom_range(0, 1)), a, $urandom, f3Tab[$urandom_range(0, 7)]);
   endtask

   // Response monitor: every pulse must match the oldest expected response, in the cycle it is due.
   always begin
      rsp_t e;
      @(posedge clock);
      #3;
      if (p0_rsp_valid || p1_rsp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, e.port ? 32'd2 : 32'd1);
            checkOutput("rsp_cycle", cycle, e.due);
            checkOutput("rsp_err", 32'(e.port ? p1_rsp_err : p0_rsp_err), 32'(e.err));
            checkOutput("rsp_rdata", e.port ? p1_rsp_rdata : p0_rsp_rdata, e.data);
         end
      end else if (expQ.size() > 0 && expQ[0].due <= cycle) begin
         e = expQ.pop_front();
         checkOutput("rsp_missing", 0, 32'(e.due));
      end
   end

   initial begin
      for (int p = 0; p < 2; p++) setReq(p, 1'b0, '0, '0, 3'b000);
      rqV[0] = 1'b0; rqV[1] = 1'b0;
      $display("[TB] start");
      doReset();

      // Reset while a load is waiting for its data: the response must vanish.
      setReq(0, 1'b0, 12'h010, '0, 3'b010);
      applyStimulus();
      doReset();
      setReq(0, 1'b0, 12'h010, '0, 3'b010);
      applyStimulus();
      applyStimulus();

      // Store then load of the same word.
      setReq(0, 1'b1, 12'h004, 32'hDEADBEEF, 3'b010);
      applyStimulus();
      setReq(0, 1'b0, 12'h004, '0, 3'b010);
      applyStimulus();
      applyStimulus();

      // Misaligned requests on port 1 get an error pulse and never reach memory.
      setReq(1, 1'b0, 12'h003, '0, 3'b001);
      applyStimulus();
      setReq(1, 1'b0, 12'h002, '0, 3'b010);
      applyStimulus();
      setReq(1, 1'b1, 12'h001, 32'h12345678, 3'b010);
      applyStimulus();
      applyStimulus();

      // Both ports loading continuously, starting straight from reset.
      doReset();
      for (int i = 0; i < 12; i++) begin
         for (int p = 0; p < 2; p++)
            if (!rqV[p]) setReq(p, 1'b0, 12'(16 * p + 4 * i), '0, 3'b010);
         applyStimulus();
      end
      rqV[0] = 1'b0; rqV[1] = 1'b0;
      applyStimulus();
      applyStimulus();

      // Port 0 asks while port 1 owns the wait cycle.
      setReq(1, 1'b0, 12'h020, '0, 3'b010);
      applyStimulus();
      setReq(0, 1'b0, 12'h024, '0, 3'b000);
      applyStimulus();
      applyStimulus();
      applyStimulus();

      // Random traffic with legal holding and occasional withdrawal of requests.
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rqV[p]) begin
               if ($urandom_range(0, 2) != 0) newRandomReq(p);
            end else if ($urandom_range(0, 9) == 0) begin
               rqV[p] = 1'b0;
            end
         end
         applyStimulus();
      end
      rqV[0] = 1'b0; rqV[1] = 1'b0;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("pending_rsp_left", 32'(expQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
